// File: rtl/serial_slice_comparator_if.sv
// Handshake bundle for serial_slice_comparator: operand request channel plus result channel.
interface serial_slice_comparator_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH / 2 + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             approx;
    logic [CW-1:0]    slices;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, gt, lt, eq, approx, slices
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, gt, lt, eq, approx, slices
    );
endinterface

// File: rtl/serial_slice_comparator.sv
// MSB-first serial magnitude comparator: one 2-bit slice per clock, early exit on the first
// unequal slice, or an approximate "equal" after APPROX_SLICES slices.
module serial_slice_comparator #(
    parameter int WIDTH         = 16,
    parameter int APPROX_SLICES = WIDTH / 2
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_slice_comparator_if.slave    bus
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TOP_IDX  = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(APPROX_SLICES);
    localparam logic          EARLY_EQ = (APPROX_SLICES < HALF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_chain;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic             r_approx;
    logic [CW-1:0]    r_slices;

    logic [1:0]       w_sa;
    logic [1:0]       w_sb;
    logic             w_h;
    logic             w_l;
    logic             w_chain_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_limit;

    // Slice idx sits at bit 2*idx; shifting it down keeps the select free of index-width games.
    assign w_sa         = 2'(r_a >> {r_idx, 1'b0});
    assign w_sb         = 2'(r_b >> {r_idx, 1'b0});
    assign w_h          = (w_sa > w_sb);
    assign w_l          = (w_sa < w_sb);
    assign w_chain_next = r_chain & ~(w_h | w_l);
    assign w_cnt_next   = r_cnt + ONE;
    assign w_limit      = (w_cnt_next == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)                w_state_next = S_RUN;
            S_RUN:   if (w_h || w_l || w_limit)       w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready)               w_state_next = S_IDLE;
            default:                                  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_chain  <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_approx <= 1'b0;
            r_slices <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_idx    <= TOP_IDX;
                        r_cnt    <= '0;
                        r_chain  <= 1'b1;
                        r_gt     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_eq     <= 1'b0;
                        r_approx <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_chain <= w_chain_next;
                    if (w_h) begin
                        r_gt     <= 1'b1;
                        r_slices <= w_cnt_next;
                    end else if (w_l) begin
                        r_lt     <= 1'b1;
                        r_slices <= w_cnt_next;
                    end else if (w_limit) begin
                        r_eq     <= w_chain_next;
                        r_approx <= EARLY_EQ;
                        r_slices <= w_cnt_next;
                    end else begin
                        r_idx <= r_idx - ONE;
                        r_cnt <= w_cnt_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.gt        = r_gt;
    assign bus.lt        = r_lt;
    assign bus.eq        = r_eq;
    assign bus.approx    = r_approx;
    assign bus.slices    = r_slices;
endmodule

// File: tb/tb_serial_slice_comparator.sv
// Directed bench for serial_slice_comparator: full-depth instance and an APPROX_SLICES=4 instance.
module tb_serial_slice_comparator;
    logic clk;
    logic rst;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_slice_comparator_if #(.WIDTH(16)) bus0 ();
    serial_slice_comparator_if #(.WIDTH(16)) bus1 ();

    serial_slice_comparator #(.WIDTH(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    serial_slice_comparator #(.WIDTH(16), .APPROX_SLICES(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Result vector layout: {out_valid, gt, lt, eq, approx, slices[3:0]}
    wire [8:0] res0 = {bus0.out_valid, bus0.gt, bus0.lt, bus0.eq, bus0.approx, bus0.slices};
    wire [8:0] res1 = {bus1.out_valid, bus1.gt, bus1.lt, bus1.eq, bus1.approx, bus1.slices};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int sel, input logic [15:0] av, input logic [15:0] bv);
        bus0.a = av; bus0.b = bv;
        bus1.a = av; bus1.b = bv;
        if (sel == 0) bus0.in_valid = 1'b1;
        else          bus1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int sel, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((sel == 0) ? bus0.out_valid : bus1.out_valid) break;
        end
    endtask

    task automatic expect_result(input int sel, input string tag, input logic [8:0] eres,
                                 input int elat);
        int lat;
        wait_out(sel, lat);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".res"}, (sel == 0) ? res0 : res1, eres);
        check({tag, ".rdy"}, (sel == 0) ? bus0.in_ready : bus1.in_ready, 0);
    endtask

    task automatic release_out(input int sel, input string tag);
        if (sel == 0) bus0.out_ready = 1'b1;
        else          bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".ovld_off"}, (sel == 0) ? bus0.out_valid : bus1.out_valid, 0);
        check({tag, ".idle"},     (sel == 0) ? bus0.in_ready  : bus1.in_ready,  1);
    endtask

    initial begin
        logic seen;

        rst            = 1'b1;
        bus0.in_valid  = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b0;
        bus1.in_valid  = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.rdy0", bus0.in_ready, 1);
        check("rst.res0", res0, 9'h000);
        check("rst.rdy1", bus1.in_ready, 1);
        check("rst.res1", res1, 9'h000);

        // MSB decision: 10 vs 01 on the first slice
        start(0, 16'h8000, 16'h7FFF);
        expect_result(0, "msb", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1}, 1);
        release_out(0, "msb");

        // LSB decision and its mirror
        start(0, 16'hA5A5, 16'hA5A4);
        expect_result(0, "lsb_gt", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8}, 8);
        release_out(0, "lsb_gt");
        start(0, 16'hA5A4, 16'hA5A5);
        expect_result(0, "lsb_lt", {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8}, 8);
        release_out(0, "lsb_lt");

        // Approximation point at 4 slices
        start(1, 16'hA5A5, 16'hA5A4);
        expect_result(1, "approx", {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4}, 4);
        release_out(1, "approx");

        // Exact equality over all slices
        start(0, 16'h1234, 16'h1234);
        expect_result(0, "exact_eq", {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8}, 8);
        release_out(0, "exact_eq");

        // New operands offered during RUN and DONE must be ignored; result held under backpressure
        start(0, 16'hA5A5, 16'hA5A4);
        bus0.a = 16'h0000; bus0.b = 16'hFFFF; bus0.in_valid = 1'b1;
        expect_result(0, "bp", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8}, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp.hold", res0, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8});
        end
        bus0.in_valid = 1'b0;
        release_out(0, "bp");
        check("bp.retain", res0, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8});
        start(0, 16'h0000, 16'hFFFF);
        expect_result(0, "bp_next", {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}, 1);
        release_out(0, "bp_next");

        // Reset while slice 3 is being evaluated
        start(0, 16'h0001, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst.rdy",  bus0.in_ready,  1);
        check("mid_rst.ovld", bus0.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | bus0.out_valid;
        end
        check("mid_rst.never_valid", seen, 0);
        check("mid_rst.res", res0, 9'h000);
        start(0, 16'h0003, 16'h0001);
        expect_result(0, "post_rst", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8}, 8);
        release_out(0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_slice_comparator.md
Name: serial_slice_comparator

Overview:
- Sequential front end for the approximate magnitude comparator. It scans two WIDTH-bit operands MSB-first, one 2-bit slice per clock.
- Each cycle it forms the two-bit-comparator flags H (A slice > B slice) and L (A slice < B slice). It also keeps a registered equality-chain bit: next = prev AND NOT(H OR L).
- It stops at the first unequal slice, or after APPROX_SLICES slices (approximation point). It then returns gt/lt/eq through a valid/ready handshake.

Parameters:
- WIDTH, 16, operand width; must be even and >= 2.
- APPROX_SLICES, WIDTH/2, number of MSB-first slices examined before declaring equal; legal range 1..WIDTH/2.
- CW, $clog2(WIDTH/2+1), width of slice counter/output (localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- gt  output  1  A > B over examined slices.
- lt  output  1  A < B over examined slices.
- eq  output  1  no difference found in examined slices.
- approx  output  1  eq declared with unexamined slices remaining.
- slices  output  CW  number of slices examined (1..APPROX_SLICES).

Behaviour:
- Reset (async, active-high):
  - state = IDLE; in_ready = 1.
  - out_valid, gt, lt, eq, approx = 0; slices = 0.
  - Internal operand registers, index and chain bit cleared.
- Reset mid-operation: an in-flight comparison is discarded and no result is produced.
- States and transitions:
  - IDLE: in_ready = 1. When in_valid && in_ready at a rising edge:
    - latch a and b;
    - idx = WIDTH/2-1 (MSB slice);
    - cnt = 0; chain = 1;
    - clear gt, lt, eq, approx;
    - go to RUN.
  - RUN: in_ready = 0. Each cycle evaluate slice idx: sa = A[2*idx+1:2*idx], sb = B[2*idx+1:2*idx].
    - H = (sa > sb), L = (sa < sb), cnt_n = cnt + 1.
    - If H: gt = 1, slices = cnt_n, go to DONE.
    - Else if L: lt = 1, slices = cnt_n, go to DONE.
    - Else if cnt_n == APPROX_SLICES: eq = 1, approx = (APPROX_SLICES < WIDTH/2), slices = cnt_n, go to DONE.
    - Else: chain stays 1, idx = idx - 1, cnt = cnt_n, stay in RUN.
    - The chain bit is cleared on a decision by H or L.
  - DONE: out_valid = 1.
    - Result outputs are held stable while out_valid && !out_ready.
    - On out_valid && out_ready: go to IDLE and deassert out_valid. gt, lt and eq retain their values until the next accept.
- Exactly one of gt/lt/eq is 1 whenever out_valid = 1. approx = 1 implies eq = 1.
- Latency: accept edge T; decision at slice k (1-based) is registered at edge T+k; out_valid is high from cycle T+k.
  - Best case k = 1; worst case k = APPROX_SLICES.
- Throughput: at most one comparison in flight. The next accept can occur no earlier than the edge after the out handshake edge, because IDLE is re-entered first.
- Inputs a, b and in_valid are ignored outside IDLE. Changes to a or b after accept have no effect.
- idx never wraps: with legal parameters, termination occurs at or before idx = 0.

Test Plan:
- Reset then idle: hold rst for 2 cycles, release -> in_ready = 1, out_valid = 0, all result outputs 0.
- MSB decision, defaults: a = 16'h8000, b = 16'h7FFF; first slice 10 vs 01 -> gt = 1, lt = 0, eq = 0, slices = 1, out_valid one cycle after accept.
- LSB decision, defaults: a = 16'hA5A5, b = 16'hA5A4 -> gt = 1, slices = 8, out_valid 8 cycles after accept. Swap the operands -> lt = 1, slices = 8.
- Approximation, APPROX_SLICES = 4: a = 16'hA5A5, b = 16'hA5A4 -> eq = 1, approx = 1, slices = 4, latency 4. Exact equal operands at the default APPROX_SLICES = 8: a = b = 16'h1234 -> eq = 1, approx = 0, slices = 8.
- Backpressure and ignore: hold out_ready = 0 for 5 cycles -> result stable and out_valid held. Toggle in_valid with new operands during RUN/DONE -> no effect. Result completes on out_ready = 1, IDLE follows, and the next accept works.
- Reset mid-RUN: assert rst at slice 3 of a = 16'h0001, b = 16'h0000 -> immediately IDLE, out_valid never asserts. Post-reset comparison a = 16'h0003, b = 16'h0001 -> gt = 1, slices = 8.
